// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared definitions for the fuzzy PI controller stages.
//   - one-hot state encoding for the accumulator FSM
//   - Q1.15 reference constants (default 16-bit word)
//   - clamp_s: signed saturating clamp; the lower limit is applied last so
//     it wins when the limits are inverted. Callers sign-extend to 32 bits.
package fuzzy_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_MUL  = 3'b010,
    S_ACC  = 3'b100
  } state_t;

  localparam int          Q_N         = 16;
  localparam logic [15:0] Q_ONE_M     = 16'h7FFF;
  localparam logic [15:0] Q_MINUS_ONE = 16'h8000;

  function automatic logic signed [31:0] clamp_s(input logic signed [31:0] x,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    logic signed [31:0] r;
    r = x;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/serial_mult_q.sv
// serial_mult_q: N-cycle signed shift-add multiplier for Q1.(N-1) operands.
//   clk, rst_n : clock, async active-low reset (clears all registers)
//   clr        : synchronous abort of a multiply in flight
//   start      : latch a, b and begin; one partial product per cycle
//   a, b       : signed Q1.(N-1) operands
//   p          : product bits [2N-2:N-1] (floor), -1 x -1 saturated to max
//   done       : one-cycle pulse after the N-th partial product
module serial_mult_q #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                start,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p,
  output logic                done
);
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MAXV = {1'b0, {(N-1){1'b1}}};

  logic [2*N-1:0] acc, mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run, sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; mcand <= '0; mplier <= '0; cnt <= '0;
      run <= 1'b0; done <= 1'b0; sat <= 1'b0;
    end else if (clr) begin
      acc <= '0; mcand <= '0; mplier <= '0; cnt <= '0;
      run <= 1'b0; done <= 1'b0; sat <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{N{a[N-1]}}, a};
      mplier <= b;
      cnt    <= '0;
      run    <= 1'b1;
      done   <= 1'b0;
      // only -1 x -1 overflows the Q1.(N-1) result range
      sat    <= (a == MINV) && (b == MINV);
    end else if (run) begin
      // the multiplier's sign bit carries weight -2^(N-1): subtract on it
      if (mplier[0]) acc <= (cnt == LAST) ? acc - mcand : acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign p = sat ? MAXV : acc[2*N-2:N-1];

endmodule

// File: rtl/fuzzy_pi_accum.sv
// fuzzy_pi_accum: incremental output integrator after the fuzzy PI controller.
//   clk, rst_n    : clock, async active-low reset (2-flop deassert sync)
//   din, gain     : increment and scale factor, Q1.(N-1), sampled with din_valid
//   din_valid     : single-cycle strobe; accepted only while idle
//   u_min, u_max  : live clamp limits (u_min wins when inverted)
//   hold          : anti-windup freeze, sampled with din
//   clr           : synchronous clear of u, FSM and ovr
//   u, u_valid    : accumulated value and its one-cycle update pulse
//   busy          : increment in progress
//   ovr           : sticky, a strobe arrived while busy
module fuzzy_pi_accum
  import fuzzy_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] din,
  input  logic                din_valid,
  input  logic signed [N-1:0] gain,
  input  logic signed [N-1:0] u_min,
  input  logic signed [N-1:0] u_max,
  input  logic                hold,
  input  logic                clr,
  output logic signed [N-1:0] u,
  output logic                u_valid,
  output logic                busy,
  output logic                ovr
);
  // async assert, synchronous release
  logic [1:0] rst_q;
  logic       rst_int_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_int_n = rst_q[1];

  state_t              state, state_nx;
  logic                accept, start, mul_done, hold_q;
  logic signed [N-1:0] p;
  logic signed [N:0]   s_sum;
  logic signed [31:0]  s_clamp;

  // busy is registered, so a strobe on the u_valid edge is still refused
  assign accept = din_valid && !busy;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      S_IDLE: if (accept) begin start = 1'b1; state_nx = S_MUL; end
      S_MUL:  if (mul_done) state_nx = S_ACC;
      S_ACC:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  serial_mult_q #(.N(N)) u_mult (
    .clk   (clk),
    .rst_n (rst_int_n),
    .clr   (clr),
    .start (start),
    .a     (din),
    .b     (gain),
    .p     (p),
    .done  (mul_done)
  );

  // N+1-bit sum cannot wrap; the clamp brings it back into range
  always_comb begin
    s_sum   = hold_q ? {u[N-1], u} : ({u[N-1], u} + {p[N-1], p});
    s_clamp = clamp_s(32'(s_sum), 32'(u_min), 32'(u_max));
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= S_IDLE; u <= '0; u_valid <= 1'b0; busy <= 1'b0;
      ovr <= 1'b0; hold_q <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE; u <= '0; u_valid <= 1'b0; busy <= 1'b0;
      ovr <= 1'b0; hold_q <= 1'b0;
    end else begin
      state   <= state_nx;
      u_valid <= 1'b0;
      if (din_valid && busy) ovr <= 1'b1;
      if (start) begin
        busy   <= 1'b1;
        hold_q <= hold;
      end
      if (state == S_ACC) begin
        u       <= s_clamp[N-1:0];
        u_valid <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_pi_accum.sv
module tb_fuzzy_pi_accum;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0, gain = '0, u_min = 16'h8000, u_max = 16'h7FFF;
  logic        din_valid = 1'b0, hold = 1'b0, clr = 1'b0;
  logic [15:0] u;
  logic        u_valid, busy, ovr;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] u_model = '0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  fuzzy_pi_accum #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .gain(gain),
    .u_min(u_min), .u_max(u_max), .hold(hold), .clr(clr),
    .u(u), .u_valid(u_valid), .busy(busy), .ovr(ovr)
  );

  // reference: full-precision product, floor to Q1.15, saturate, add, clamp
  function automatic logic [15:0] model(input logic [15:0] u0, d, g,
                                        input logic h,
                                        input logic [15:0] mn, mx);
    int ui, di, gi, pr, s, lo, hi;
    ui = int'($signed(u0)); di = int'($signed(d)); gi = int'($signed(g));
    lo = int'($signed(mn)); hi = int'($signed(mx));
    pr = (di * gi) >>> 15;
    if (pr > 32767) pr = 32767;
    s = h ? ui : ui + pr;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one-cycle strobe; returns just after edge 0
  task automatic strobe(input logic [15:0] d, g, input logic h);
    @(negedge clk);
    din = d; gain = g; hold = h; din_valid = 1'b1;
    u_model = model(u_model, d, g, h, u_min, u_max);
    sb_q.push_back(u_model);
    @(negedge clk);
    din_valid = 1'b0; hold = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  // wait (bounded) for u_valid; start = edges already elapsed since edge 0
  task automatic wait_uv(input int start);
    int cnt;
    bit seen;
    cnt = start; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (u_valid) seen = 1'b1;
    end
    check("uv_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("latency", cnt, 32'd18);
      check("sb_size", sb_q.size(), 32'd1);
      if (sb_q.size() > 0) check("u_value", {16'd0, u}, {16'd0, sb_q.pop_front()});
      check("busy_fall", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("uv_pulse", {31'd0, u_valid}, 32'd0);
    end
  endtask

  task automatic no_uv(input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (u_valid) hits++;
    end
    check("no_extra_uv", hits, 32'd0);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    u_model = '0;
    check("clr_u", {16'd0, u}, 32'd0);
    check("clr_ovr", {31'd0, ovr}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_u", {16'd0, u}, 32'd0);
    check("rst_uv", {31'd0, u_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, ovr}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic accumulation: 0x1000 then 0x2000
    strobe(16'h2000, 16'h4000, 1'b0); wait_uv(0);
    strobe(16'h2000, 16'h4000, 1'b0); wait_uv(0);

    // saturation at u_max, then negative clamp at u_min
    do_clr();
    u_max = 16'h6000;
    repeat (4) begin strobe(16'h7FFF, 16'h7FFF, 1'b0); wait_uv(0); end
    u_min = 16'hA000;
    repeat (3) begin strobe(16'h8000, 16'h7FFF, 1'b0); wait_uv(0); end

    // corner products
    do_clr();
    u_min = 16'h8000; u_max = 16'h7FFF;
    strobe(16'h8000, 16'h8000, 1'b0); wait_uv(0);
    do_clr();
    strobe(16'h8000, 16'h7FFF, 1'b0); wait_uv(0);

    // overrun: second strobe sampled at edge 5 is dropped
    do_clr();
    strobe(16'h2000, 16'h4000, 1'b0);
    repeat (4) @(negedge clk);
    din = 16'h7000; gain = 16'h7FFF; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("ovr_set", {31'd0, ovr}, 32'd1);
    wait_uv(5);
    no_uv(25);
    check("ovr_sticky", {31'd0, ovr}, 32'd1);
    do_clr();

    // hold: value frozen, but still clamped to a lowered u_max
    strobe(16'h2000, 16'h4000, 1'b0); wait_uv(0);
    strobe(16'h2000, 16'h4000, 1'b1); wait_uv(0);
    u_max = 16'h0800;
    strobe(16'h2000, 16'h4000, 1'b1); wait_uv(0);

    // reset in the middle of the multiply
    strobe(16'h2000, 16'h4000, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_u", {16'd0, u}, 32'd0);
    check("arst_uv", {31'd0, u_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovr", {31'd0, ovr}, 32'd0);
    sb_q.delete();
    u_model = '0;
    u_max = 16'h7FFF;
    no_uv(3);
    rst_n = 1'b1;
    no_uv(25);
    strobe(16'h2000, 16'h4000, 1'b0); wait_uv(0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
